mem_word_arb: RTL
=================

MEM_WORD_ARB -- requirements
Module: mem_word_arb

Interface
REQ-001 SHALL have parameter ADR_W, default 14, byte-address width of the shared byte-wide memory.
REQ-002 SHALL have ports: clk input 1, sole clock; all logic on rising edge.
REQ-003 SHALL have ports: rst input 1, reset; synchronous and active-high.
REQ-004 SHALL have instruction port: im_req in 1 (read request), im_adr in ADR_W (byte address), im_dat_o out 32 (read word), im_ack out 1 (done pulse).
REQ-005 SHALL have data port: dm_req in 1, dm_we in 1, dm_sel in 4 (byte enables, bit3 = byte 0), dm_adr in ADR_W, dm_dat_i in 32, dm_dat_o out 32, dm_ack out 1, dm_err out 1.
REQ-006 SHALL have memory port: mem_adr out ADR_W, mem_dat_o out 8 (write data), mem_dat_i in 8 (read data, valid one cycle after mem_en), mem_we out 1, mem_en out 1.

Function
REQ-007 SHALL serve one 32-bit word transaction at a time as four byte accesses at {adr[ADR_W-1:2], k}, with k = 0,1,2,3 in order.
REQ-008 SHALL use big-endian lane mapping: byte k maps to word bits [31-8k : 24-8k].
REQ-009 SHALL sample requests only in IDLE; requesters hold req/adr/we/sel/dat stable until their ack, and drop req on the edge where ack is seen.
REQ-010 SHALL arbitrate round-robin: a single requester is granted; on a tie, grant the port not served last; after reset "last served" = im, so dm wins the first tie.
REQ-011 SHALL follow state sequence IDLE -> B0 -> B1 -> B2 -> B3 -> CAP (reads only) -> ACK -> IDLE.
REQ-012 Read timing SHALL be: req seen in IDLE at cycle T; mem_en=1, mem_we=0 in cycles T+1..T+4; byte k captured the cycle after it is issued; ack at T+6.
REQ-013 Write timing SHALL be: mem_en = dm_sel[3-k] and mem_we = 1 in Bk; mem_dat_o = byte k of dm_dat_i; no CAP state; dm_ack at T+5.
REQ-014 dm_sel = 4'b0000 write SHALL issue no mem_en and SHALL still ack at T+5.
REQ-015 ack SHALL be a one-cycle pulse asserted only on the granted port; im_dat_o and dm_dat_o SHALL be registered, valid from ack, and held until that port's next read completes.
REQ-016 mem_en SHALL be 0 in IDLE, CAP and ACK; mem_adr, mem_dat_o and mem_we are don't-care whenever mem_en=0.
REQ-017 SHALL have no back-to-back overlap: the earliest next grant is the IDLE cycle following ACK.

Reset
REQ-018 rst SHALL force, on the next edge: state IDLE, mem_en=0, mem_we=0, both acks=0, dm_err=0, im_dat_o=0, dm_dat_o=0, last served = im.
REQ-019 rst mid-transaction SHALL abort it with no ack; bytes already written stay written.

Configuration
REQ-020 With MEM_WORD_ARB_MISALIGN_ERR_EN defined, a dm request with dm_adr[1:0] != 0 SHALL issue no memory access and SHALL pulse dm_err one cycle at T+1 instead of dm_ack, then return to IDLE.
REQ-021 Without MEM_WORD_ARB_MISALIGN_ERR_EN, adr[1:0] SHALL be ignored on both ports and dm_err SHALL be tied 0.

Structure
REQ-022 Package mem_word_arb_pkg SHALL hold the state encoding, the byte-lane index constants and the default ADR_W.
REQ-023 Round-robin grant logic SHALL be sub-module mem_rr_arb2 (inputs: two reqs, enable, last-served; outputs: one-hot grant); all else in mem_word_arb.

Verification
REQ-024 dm write 0x11223344 to 0x0100, sel=4'hF; then im read 0x0100 -> mem writes 0x11,0x22,0x33,0x44 at 0x0100..0x0103; im_dat_o=0x11223344; im_ack exactly 6 cycles after req sampled.
REQ-025 dm write 0xAABBCCDD, sel=4'b0101 over a word holding 0x11223344; then read -> 0x11BB33DD; mem_en high only in B1 and B3.
REQ-026 im and dm both request in the same IDLE cycle immediately after reset -> dm served first, im next; with both held continuously, grants alternate dm, im, dm, im.
REQ-027 rst asserted in B2 of a write of 0xCAFEF00D to 0x0200 -> no ack; bytes 0x0200 and 0x0201 read back 0xCA and 0xFE; outputs at reset values.
REQ-028 Macro defined: dm read at 0x0102 -> dm_err pulse at T+1, no mem_en, no dm_ack; macro undefined: same access returns the word at 0x0100.
REQ-029 Read at top word 0x3FFC -> mem_adr sequence 0x3FFC..0x3FFF, no wrap into 0x0000.

Source files
------------

// File: rtl/mem_word_arb_pkg.sv
// rtl/mem_word_arb_pkg.sv - shared types and constants for the word-over-byte memory arbiter
package mem_word_arb_pkg;

   localparam int ADR_W_DEF = 14;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_B0   = 3'd1,
      ST_B1   = 3'd2,
      ST_B2   = 3'd3,
      ST_B3   = 3'd4,
      ST_CAP  = 3'd5,
      ST_ACK  = 3'd6,
      ST_ERR  = 3'd7
   } state_e;

   localparam logic [1:0] LANE0 = 2'd0;
   localparam logic [1:0] LANE1 = 2'd1;
   localparam logic [1:0] LANE2 = 2'd2;
   localparam logic [1:0] LANE3 = 2'd3;

   // Big-endian: byte 0 sits in the most significant lane.
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
      case (k)
         LANE0:   return w[31:24];
         LANE1:   return w[23:16];
         LANE2:   return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

endpackage

// File: rtl/mem_word_arb_rr_arb2.sv
// rtl/mem_word_arb_rr_arb2.sv - two-way round-robin grant, one-hot {dm, im}
module mem_rr_arb2 (
   input  logic       req_im_i,
   input  logic       req_dm_i,
   input  logic       en_i,
   input  logic       last_dm_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (req_im_i && req_dm_i) begin
            gnt_o = last_dm_i ? 2'b01 : 2'b10;
         end else if (req_dm_i) begin
            gnt_o = 2'b10;
         end else if (req_im_i) begin
            gnt_o = 2'b01;
         end
      end
   end

endmodule

// File: rtl/mem_word_arb.sv
// rtl/mem_word_arb.sv - instruction/data word ports sharing one byte-wide memory
// Optional MEM_WORD_ARB_MISALIGN_ERR_EN: misaligned dm requests get a dm_err pulse, no access.
module mem_word_arb
   import mem_word_arb_pkg::*;
#(
   parameter int ADR_W = ADR_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             im_req,
   input  logic [ADR_W-1:0] im_adr,
   output logic [31:0]      im_dat_o,
   output logic             im_ack,
   input  logic             dm_req,
   input  logic             dm_we,
   input  logic [3:0]       dm_sel,
   input  logic [ADR_W-1:0] dm_adr,
   input  logic [31:0]      dm_dat_i,
   output logic [31:0]      dm_dat_o,
   output logic             dm_ack,
   output logic             dm_err,
   output logic [ADR_W-1:0] mem_adr,
   output logic [7:0]       mem_dat_o,
   input  logic [7:0]       mem_dat_i,
   output logic             mem_we,
   output logic             mem_en
);

   state_e           state_q, state_d;
   logic             gnt_dm_q, gnt_dm_d;
   logic             last_dm_q, last_dm_d;
   logic [23:0]      rd_q, rd_d;
   logic [31:0]      im_dat_q, im_dat_d;
   logic [31:0]      dm_dat_q, dm_dat_d;
   logic [1:0]       gnt;
   logic [1:0]       lane;
   logic             is_wr;
   logic [ADR_W-1:0] cur_adr;
   logic             adr_lo_unused;

   mem_rr_arb2 u_arb (
      .req_im_i  (im_req),
      .req_dm_i  (dm_req),
      .en_i      (state_q == ST_IDLE),
      .last_dm_i (last_dm_q),
      .gnt_o     (gnt)
   );

   // Requesters hold their inputs until ack, so the live inputs are used directly.
   assign is_wr         = gnt_dm_q & dm_we;
   assign cur_adr       = gnt_dm_q ? dm_adr : im_adr;
   assign adr_lo_unused = ^cur_adr[1:0];
   assign mem_adr       = {cur_adr[ADR_W-1:2], lane};
   assign mem_dat_o     = word_byte(dm_dat_i, lane);
   assign im_dat_o      = im_dat_q;
   assign dm_dat_o      = dm_dat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         gnt_dm_q  <= 1'b0;
         last_dm_q <= 1'b0;
         rd_q      <= 24'd0;
         im_dat_q  <= 32'd0;
         dm_dat_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         gnt_dm_q  <= gnt_dm_d;
         last_dm_q <= last_dm_d;
         rd_q      <= rd_d;
         im_dat_q  <= im_dat_d;
         dm_dat_q  <= dm_dat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_dm_d  = gnt_dm_q;
      last_dm_d = last_dm_q;
      rd_d      = rd_q;
      im_dat_d  = im_dat_q;
      dm_dat_d  = dm_dat_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               gnt_dm_d  = gnt[1];
               last_dm_d = gnt[1];
               state_d   = ST_B0;
`ifdef MEM_WORD_ARB_MISALIGN_ERR_EN
               if (gnt[1] && (dm_adr[1:0] != 2'b00)) state_d = ST_ERR;
`endif
            end
         end
         ST_B0: state_d = ST_B1;
         // Memory read data trails the issue cycle by one, so byte k lands in the next state.
         ST_B1: begin
            state_d      = ST_B2;
            rd_d[23:16]  = mem_dat_i;
         end
         ST_B2: begin
            state_d      = ST_B3;
            rd_d[15:8]   = mem_dat_i;
         end
         ST_B3: begin
            state_d      = is_wr ? ST_ACK : ST_CAP;
            rd_d[7:0]    = mem_dat_i;
         end
         ST_CAP: begin
            state_d = ST_ACK;
            if (gnt_dm_q) dm_dat_d = {rd_q, mem_dat_i};
            else          im_dat_d = {rd_q, mem_dat_i};
         end
         ST_ACK:  state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      lane   = LANE0;
      mem_en = 1'b0;
      mem_we = 1'b0;
      im_ack = 1'b0;
      dm_ack = 1'b0;
      case (state_q)
         ST_B0, ST_B1, ST_B2, ST_B3: begin
            case (state_q)
               ST_B1:   lane = LANE1;
               ST_B2:   lane = LANE2;
               ST_B3:   lane = LANE3;
               default: lane = LANE0;
            endcase
            mem_en = is_wr ? dm_sel[LANE3 - lane] : 1'b1;
            mem_we = is_wr;
         end
         ST_ACK: begin
            im_ack = ~gnt_dm_q;
            dm_ack = gnt_dm_q;
         end
         default: ;
      endcase
   end

`ifdef MEM_WORD_ARB_MISALIGN_ERR_EN
   assign dm_err = (state_q == ST_ERR);
`else
   assign dm_err = 1'b0;
`endif

endmodule
